dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory controller.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W  = 32;
   localparam int unsigned DMEM_DEPTH   = 1024;
   localparam int unsigned DMEM_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: byte-enable write, registered read.
// The read register returns zero for writes and rejected addresses.
module dmem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                we,
   input  logic                addr_ok,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata
);

   localparam int unsigned NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (en && we && addr_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= (!we && addr_ok) ? mem[addr] : '0;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding request, fixed LATENCY to response.
// Define DMEM_BOUND_CHECK_EN to flag addresses >= DEPTH instead of wrapping.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W  = DMEM_DATA_W,
   parameter int unsigned DEPTH   = DMEM_DEPTH,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LATENCY = DMEM_LATENCY
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = DATA_W / 8;
`ifdef DMEM_BOUND_CHECK_EN
   localparam int unsigned LA_W = ADDR_W;
`else
   localparam int unsigned LA_W = AW;
`endif
   localparam logic [2:0] CNT_INIT = 3'((LATENCY > 1) ? LATENCY - 2 : 32'd0);

   state_t            state, state_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic              accept, access;

   logic              lat_write;
   logic [LA_W-1:0]   lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [NB-1:0]     lat_be;

   logic              acc_write;
   logic [LA_W-1:0]   acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [NB-1:0]     acc_be;
   logic              addr_ok;

   // With LATENCY=1 the access happens on the accept edge, so use the live request.
   always_comb begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (state == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr[LA_W-1:0];
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

`ifdef DMEM_BOUND_CHECK_EN
   assign addr_ok = (acc_addr < LA_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst)         rsp_err <= 1'b0;
      else if (access) rsp_err <= !addr_ok;
   end
`else
   logic unused_addr_hi;
   assign addr_ok        = 1'b1;
   assign rsp_err        = 1'b0;
   assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  access    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_nxt = RESP;
               access    = 1'b1;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         busy      <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write <= req_write;
         lat_addr  <= req_addr[LA_W-1:0];
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .en      (access && !rst),
      .we      (acc_write),
      .addr_ok (addr_ok),
      .addr    (acc_addr[AW-1:0]),
      .wdata   (acc_wdata),
      .be      (acc_be),
      .rdata   (rsp_rdata)
   );

endmodule
